// File: rtl/wb_cpu_bus_master_pkg.sv
// Shared bus definitions for the CPU-to-Wishbone master: operation codes,
// completion error codes and FSM state encoding.
package wb_cpu_bus_master_pkg;

    localparam logic [3:0] BUSOP_READB  = 4'h0;
    localparam logic [3:0] BUSOP_READBU = 4'h1;
    localparam logic [3:0] BUSOP_READH  = 4'h2;
    localparam logic [3:0] BUSOP_READHU = 4'h3;
    localparam logic [3:0] BUSOP_READW  = 4'h4;
    localparam logic [3:0] BUSOP_READT  = 4'h5;
    localparam logic [3:0] BUSOP_WRITEB = 4'h8;
    localparam logic [3:0] BUSOP_WRITEH = 4'h9;
    localparam logic [3:0] BUSOP_WRITEW = 4'hA;
    localparam logic [3:0] BUSOP_WRITET = 4'hB;

    localparam logic [1:0] BUSERR_NONE     = 2'd0;
    localparam logic [1:0] BUSERR_MISALIGN = 2'd1;
    localparam logic [1:0] BUSERR_BUS      = 2'd2;
    localparam logic [1:0] BUSERR_TIMEOUT  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Unknown op codes collapse to a byte read, as the legacy master did.
    function automatic logic [3:0] busop_norm(input logic [3:0] op);
        case (op)
            BUSOP_READB, BUSOP_READBU, BUSOP_READH, BUSOP_READHU,
            BUSOP_READW, BUSOP_READT, BUSOP_WRITEB, BUSOP_WRITEH,
            BUSOP_WRITEW, BUSOP_WRITET: busop_norm = op;
            default:                    busop_norm = BUSOP_READB;
        endcase
    endfunction

endpackage

// File: rtl/wb_cpu_bus_master_lane_steer.sv
// Byte-lane steering: alignment check, byte selects, write data placement
// and read data extraction/extension for one bus operation.
module wb_lane_steer
    import wb_cpu_bus_master_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [3:0]                  i_op,
    input  logic [$clog2(DATA_W/8)-1:0] i_off,
    input  logic [31:0]                 i_wdata,
    input  logic [DATA_W-1:0]           i_rdata,
    output logic                        o_misalign,
    output logic                        o_we,
    output logic [DATA_W/8-1:0]         o_sel,
    output logic [DATA_W-1:0]           o_wdata,
    output logic [31:0]                 o_rdata
);

    localparam int SEL_W = DATA_W / 8;

    logic [3:0]       w_op;
    logic [SEL_W-1:0] w_base;
    logic [31:0]      w_r;

    assign w_op    = busop_norm(i_op);
    assign o_we    = w_op[3];
    assign o_sel   = w_base << i_off;
    assign o_wdata = DATA_W'(i_wdata) << {i_off, 3'b000};
    assign w_r     = 32'(i_rdata >> {i_off, 3'b000});

    // Base lane mask and alignment requirement per access size.
    always_comb begin
        w_base     = SEL_W'(4'h1);
        o_misalign = 1'b0;
        case (w_op)
            BUSOP_READH, BUSOP_READHU, BUSOP_WRITEH: begin
                w_base     = SEL_W'(4'h3);
                o_misalign = i_off[0];
            end
            BUSOP_READW, BUSOP_WRITEW: begin
                w_base     = SEL_W'(4'hF);
                o_misalign = |i_off[1:0];
            end
            BUSOP_READT, BUSOP_WRITET: begin
                w_base     = SEL_W'(4'h5);
                o_misalign = |i_off[1:0];
            end
            default: begin
                w_base     = SEL_W'(4'h1);
                o_misalign = 1'b0;
            end
        endcase
    end

    // Sign/zero extension of the lane-shifted read data.
    always_comb begin
        o_rdata = w_r;
        case (w_op)
            BUSOP_READB:  o_rdata = {{24{w_r[7]}}, w_r[7:0]};
            BUSOP_READBU: o_rdata = {24'b0, w_r[7:0]};
            BUSOP_READH:  o_rdata = {{16{w_r[15]}}, w_r[15:0]};
            BUSOP_READHU: o_rdata = {16'b0, w_r[15:0]};
            BUSOP_READT:  o_rdata = {28'b0, w_r[3:0]};
            default:      o_rdata = w_r;
        endcase
    end

endmodule

// File: rtl/wb_cpu_bus_master.sv
// CPU load/store to Wishbone B4 classic master: single outstanding access,
// registered bus outputs, ERR_I handling and a bus timeout watchdog.
module wb_cpu_bus_master
    import wb_cpu_bus_master_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                CLK_I,
    input  logic                RST_N_I,
    input  logic                I_en,
    input  logic [3:0]          I_op,
    input  logic [ADDR_W-1:0]   I_addr,
    input  logic [31:0]         I_data,
    output logic [31:0]         O_data,
    output logic                O_busy,
    output logic                O_done,
    output logic                O_err,
    output logic [1:0]          O_err_code,
    input  logic                ACK_I,
    input  logic                ERR_I,
    input  logic [DATA_W-1:0]   DAT_I,
    output logic [ADDR_W-1:0]   ADR_O,
    output logic [DATA_W-1:0]   DAT_O,
    output logic [DATA_W/8-1:0] SEL_O,
    output logic                CYC_O,
    output logic                STB_O,
    output logic                WE_O
);

    localparam int SEL_W = DATA_W / 8;
    localparam int OFF_W = $clog2(SEL_W);
    // A disabled watchdog still keeps a 1-bit counter so no zero-width vector exists.
    localparam int CNT_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [3:0]          r_op;
    logic [OFF_W-1:0]    r_off;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_cyc;
    logic                r_stb;
    logic                r_we;
    logic [ADDR_W-1:0]   r_adr;
    logic [SEL_W-1:0]    r_sel;
    logic [DATA_W-1:0]   r_dat_o;
    logic [31:0]         r_data;
    logic [1:0]          r_err_code;

    logic [3:0]          w_op;
    logic [OFF_W-1:0]    w_off;
    logic                w_misalign;
    logic                w_we;
    logic [SEL_W-1:0]    w_sel;
    logic [DATA_W-1:0]   w_wdata;
    logic [31:0]         w_rdata;
    logic [CNT_W-1:0]    w_cnt_nxt;
    logic                w_timeout;
    logic                w_bus_end;

    // In IDLE the steering looks at the incoming request; afterwards at the latched one.
    assign w_op  = (r_state == ST_IDLE) ? I_op : r_op;
    assign w_off = (r_state == ST_IDLE) ? I_addr[OFF_W-1:0] : r_off;

    wb_lane_steer #(
        .DATA_W (DATA_W)
    ) u_steer (
        .i_op       (w_op),
        .i_off      (w_off),
        .i_wdata    (I_data),
        .i_rdata    (DAT_I),
        .o_misalign (w_misalign),
        .o_we       (w_we),
        .o_sel      (w_sel),
        .o_wdata    (w_wdata),
        .o_rdata    (w_rdata)
    );

    assign w_cnt_nxt = r_cnt + CNT_W'(1);
    assign w_timeout = (TIMEOUT_CYC != 0) && (w_cnt_nxt == CNT_W'(TIMEOUT_CYC));
    assign w_bus_end = ERR_I || ACK_I || w_timeout;

    // FSM state register.
    always_ff @(posedge CLK_I or negedge RST_N_I) begin
        if (!RST_N_I) r_state <= ST_IDLE;
        else          r_state <= w_state_nxt;
    end

    // FSM next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (I_en) w_state_nxt = w_misalign ? ST_RESP : ST_BUS;
            ST_BUS:  if (w_bus_end) w_state_nxt = ST_RESP;
            ST_RESP: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Bus output registers, request latch, watchdog and completion status.
    always_ff @(posedge CLK_I or negedge RST_N_I) begin
        if (!RST_N_I) begin
            r_op       <= '0;
            r_off      <= '0;
            r_cnt      <= '0;
            r_cyc      <= 1'b0;
            r_stb      <= 1'b0;
            r_we       <= 1'b0;
            r_adr      <= '0;
            r_sel      <= '0;
            r_dat_o    <= '0;
            r_data     <= '0;
            r_err_code <= BUSERR_NONE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (I_en) begin
                        r_op  <= I_op;
                        r_off <= I_addr[OFF_W-1:0];
                        r_cnt <= '0;
                        if (w_misalign) begin
                            r_err_code <= BUSERR_MISALIGN;
                        end else begin
                            r_err_code <= BUSERR_NONE;
                            r_cyc      <= 1'b1;
                            r_stb      <= 1'b1;
                            r_we       <= w_we;
                            r_adr      <= {I_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
                            r_sel      <= w_sel;
                            r_dat_o    <= w_wdata;
                        end
                    end
                end
                ST_BUS: begin
                    r_cnt <= w_cnt_nxt;
                    if (w_bus_end) begin
                        r_cyc <= 1'b0;
                        r_stb <= 1'b0;
                        r_we  <= 1'b0;
                        r_sel <= '0;
                        // ERR_I takes priority over a simultaneous ACK_I.
                        if (ERR_I) begin
                            r_err_code <= BUSERR_BUS;
                        end else if (ACK_I) begin
                            r_err_code <= BUSERR_NONE;
                            if (!r_we) r_data <= w_rdata;
                        end else begin
                            r_err_code <= BUSERR_TIMEOUT;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign O_busy     = (r_state == ST_BUS);
    assign O_done     = (r_state == ST_RESP);
    assign O_err      = O_done && (r_err_code != BUSERR_NONE);
    assign O_err_code = O_done ? r_err_code : BUSERR_NONE;
    assign O_data     = r_data;
    assign CYC_O      = r_cyc;
    assign STB_O      = r_stb;
    assign WE_O       = r_we;
    assign ADR_O      = r_adr;
    assign SEL_O      = r_sel;
    assign DAT_O      = r_dat_o;

endmodule

// File: doc/wb_cpu_bus_master.md
Name: wb_cpu_bus_master

Overview:
Parametrised successor to the single-cycle-issue CPU-to-Wishbone B4 classic master. It adds configurable data width and true byte-lane steering from low address bits. It also adds misalignment detection, ERR_I handling, a bus timeout watchdog and an explicit completion/error report to the CPU. The block sits between the CPU load/store unit and the system Wishbone interconnect (RAM, devices).

Parameters:
DATA_W, 32, Wishbone data width; legal values 32 or 64.
ADDR_W, 32, byte address width.
TIMEOUT_CYC, 255, cycles in BUS state before forced abort; 0 disables the watchdog.

Ports:
CLK_I  in  1  clock
RST_N_I  in  1  asynchronous active-low reset
I_en  in  1  request strobe; sampled only in IDLE
I_op  in  4  BUSOP_* code from shared bus definitions
I_addr  in  ADDR_W  byte address
I_data  in  32  write data, right-aligned
O_data  out  32  read result, extended per op; held until next completion
O_busy  out  1  high from the cycle after accept until completion
O_done  out  1  one-cycle pulse on completion (success or error)
O_err  out  1  valid with O_done; 1 = failed
O_err_code  out  2  0 none, 1 misaligned, 2 bus ERR_I, 3 timeout
ACK_I  in  1  Wishbone ack
ERR_I  in  1  Wishbone error
DAT_I  in  DATA_W  Wishbone read data
ADR_O  out  ADDR_W  lane-aligned address (low log2(DATA_W/8) bits zero)
DAT_O  out  DATA_W  steered write data
SEL_O  out  DATA_W/8  byte selects
CYC_O, STB_O, WE_O  out  1 each  Wishbone cycle, strobe and write enable

Behaviour:
- Reset: all outputs 0. State = IDLE. O_data = 0. Timeout counter = 0. Takes effect asynchronously, mid-cycle included: CYC_O and STB_O drop immediately.
- FSM states: IDLE, BUS, RESP.
  - IDLE + I_en + misaligned -> RESP. No bus cycle is issued; err_code = 1.
  - IDLE + I_en + aligned -> BUS. In the next cycle CYC_O, STB_O, WE_O, ADR_O, SEL_O and DAT_O are registered and valid; O_busy = 1.
  - BUS: STB_O and CYC_O are held and the outputs stay stable until ACK_I, ERR_I or timeout.
    - ACK_I -> RESP with O_data captured.
    - ERR_I -> RESP, err_code 2; O_data is unchanged.
    - If ACK_I and ERR_I are high in the same cycle, ERR_I wins.
    - Counter reaches TIMEOUT_CYC -> RESP, err_code 3.
    - In all three cases CYC_O, STB_O, WE_O and SEL_O are 0 in the following cycle.
  - RESP: O_done = 1 and O_busy = 0 for exactly one cycle, then -> IDLE.
- Latency: accept in cycle N; first bus cycle N+1. Zero-wait ACK in cycle N+1 gives O_done in N+2. Next request accepted in N+3 at the earliest (I_en is sampled in IDLE).
- I_en while not in IDLE is ignored and not queued.
- Alignment: halfword needs addr[0] = 0; word needs addr[1:0] = 0; tag ops need addr[1:0] = 0. Byte ops are always aligned.
- Lane offset: off = addr[log2(DATA_W/8)-1:0].
  - SEL_O = base_mask << off, with base masks byte 1, half 3, word 'hF, tag 'h5.
  - DAT_O = I_data << (8*off). Unused lanes are 0.
- Read extraction: r = DAT_I >> (8*off).
  - READB/READBU: sign- or zero-extend r[7:0].
  - READH/READHU: sign- or zero-extend r[15:0].
  - READW: r[31:0].
  - READT: zero-extend r[3:0].
- Undefined I_op: treated as READB. This matches the legacy default.
- Timeout counter: width $clog2(TIMEOUT_CYC+1). Cleared on entry to BUS; increments each BUS cycle.
- ACK_I or ERR_I outside BUS: ignored.

Decomposition:
- Shared bus-definitions package (busdefs):
  - BUSOP_* codes.
  - BUSERR_NONE/MISALIGN/BUS/TIMEOUT constants.
  - State encodings.
- Sub-module wb_lane_steer: combinational. Computes the misalign flag, SEL_O, steered DAT_O and extended read data from op, offset and DATA_W.
- The top level holds only the FSM, the registers and the watchdog.

Test Plan:
1. DATA_W=32, WRITEB addr 0x1003, data 0xAB, ACK_I one cycle after STB_O. Required: SEL_O=4'b1000, DAT_O=0xAB000000, ADR_O=0x1000, WE_O=1; O_done pulse with O_err=0.
2. DATA_W=64, READH addr 0x2006, DAT_I=0x8001_0000_0000_0000. Required: SEL_O=8'hC0, O_data=0xFFFF8001. Repeat with READHU: O_data=0x00008001.
3. READW addr 0x3002. Required: no CYC_O assertion; O_done after 1 cycle with O_err=1 and O_err_code=1.
4. READW with ERR_I and ACK_I asserted together. Required: O_err_code=2; O_data keeps its prior value; CYC_O=0 next cycle.
5. TIMEOUT_CYC=4, no ACK_I. Required: STB_O high for exactly 4 cycles, then dropped; O_err_code=3. A repeat with TIMEOUT_CYC=0 must wait 1000 cycles without aborting.
6. RST_N_I pulled low while in BUS with STB_O=1. Required: CYC_O, STB_O and O_busy go 0 without a clock edge. After release, a new READW completes normally, and I_en pulses during BUS are ignored.
